// File: rtl/mcs4_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mcs4_bus_arbiter: MCS-4 phase tracker and fixed-priority data-bus arbiter |
// | Optional feature macro MCS4_BUS_ERR_EN adds conflict error counters. Rev 1.0 |
// +--------------------------------------------------------------------------+
module mcs4_bus_arbiter #(
  parameter int unsigned        N_REQ      = 4,
  parameter logic [8*N_REQ-1:0] PHASE_MASK = {N_REQ{8'hFF}},
  parameter int unsigned        RESYNC     = 1
) (
  input  logic                 sysclk,
  input  logic                 poc_pad,
  input  logic                 clk2_pad,
  input  logic                 sync_pad,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   req_data,
`ifdef MCS4_BUS_ERR_EN
  input  logic                 err_clear,
  output logic                 err_sticky,
  output logic [7:0]           err_count,
`endif
  output logic [N_REQ-1:0]     grant,
  output logic [3:0]           data_out,
  output logic                 data_dir,
  output logic [2:0]           phase,
  output logic                 phase_valid,
  output logic                 conflict
);

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_X3 = 3'd7;

  logic clk2_s0_d, clk2_s0_q;
  logic sync_s0_d, sync_s0_q;
  logic clk2_prev_d, clk2_prev_q;
  logic clk2_smp, sync_smp;
  logic clk2_rise;

  always_comb begin
    clk2_s0_d   = clk2_pad;
    sync_s0_d   = sync_pad;
    clk2_prev_d = clk2_smp;
  end

  // Pad samplers carry no state worth resetting; they flush within a few cycles.
  always_ff @(posedge sysclk) begin
    clk2_s0_q   <= clk2_s0_d;
    sync_s0_q   <= sync_s0_d;
    clk2_prev_q <= clk2_prev_d;
  end

  generate
    if (RESYNC != 0) begin : g_resync
      logic clk2_s1_q, sync_s1_q;
      always_ff @(posedge sysclk) begin
        clk2_s1_q <= clk2_s0_q;
        sync_s1_q <= sync_s0_q;
      end
      assign clk2_smp = clk2_s1_q;
      assign sync_smp = sync_s1_q;
    end else begin : g_direct
      assign clk2_smp = clk2_s0_q;
      assign sync_smp = sync_s0_q;
    end
  endgenerate

  assign clk2_rise = clk2_smp & ~clk2_prev_q;

  logic [2:0] phase_d, phase_q;
  logic       phase_valid_d, phase_valid_q;

  always_comb begin
    phase_d       = phase_q;
    phase_valid_d = phase_valid_q;
    if (clk2_rise) begin
      if (sync_smp) begin
        phase_d       = PH_A1;
        phase_valid_d = 1'b1;
      end else begin
        phase_d = phase_q + 3'd1;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (poc_pad) begin
      phase_q       <= PH_X3;
      phase_valid_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
    end
  end

  logic [N_REQ-1:0] eligible;
  logic [3:0]       nib [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_elig
      localparam logic [7:0] SLICE = PHASE_MASK[8*gi +: 8];
      assign eligible[gi] = req[gi] & SLICE[phase_q] & phase_valid_q;
      assign nib[gi]      = req_data[4*gi +: 4];
    end
  endgenerate

  logic [N_REQ-1:0] grant_d, grant_q;
  logic [3:0]       data_out_d, data_out_q;
  logic             data_dir_d, data_dir_q;
  logic             conflict_d, conflict_q;
  logic [3:0]       elig_cnt;

  // Scan from the top down so the lowest eligible index is the last writer.
  always_comb begin
    grant_d    = '0;
    data_out_d = '0;
    elig_cnt   = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_d    = '0;
        grant_d[i] = 1'b1;
        data_out_d = nib[i];
      end
      elig_cnt = elig_cnt + {3'd0, eligible[i]};
    end
    data_dir_d = |grant_d;
    conflict_d = (elig_cnt > 4'd1);
  end

  always_ff @(posedge sysclk) begin
    if (poc_pad) begin
      grant_q    <= '0;
      data_out_q <= '0;
      data_dir_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      data_out_q <= data_out_d;
      data_dir_q <= data_dir_d;
      conflict_q <= conflict_d;
    end
  end

  assign grant       = grant_q;
  assign data_out    = data_out_q;
  assign data_dir    = data_dir_q;
  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign conflict    = conflict_q;

`ifdef MCS4_BUS_ERR_EN
  logic [7:0] err_count_d, err_count_q;
  logic       err_sticky_d, err_sticky_q;

  // A clear coinciding with a conflict restarts the count at that conflict.
  always_comb begin
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;
    if (err_clear) begin
      err_count_d  = {7'd0, conflict_d};
      err_sticky_d = conflict_d;
    end else if (conflict_d) begin
      err_sticky_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (poc_pad) begin
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_count  = err_count_q;
  assign err_sticky = err_sticky_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mcs4_bus_arbiter.sv
`default_nettype none
// tb_mcs4_bus_arbiter: two arbiter instances (restricted and open phase masks)
// driven by random and directed steps, checked against a behavioural model.
module tb_mcs4_bus_arbiter;

  localparam int          N      = 4;
  localparam int          RS     = 1;
  localparam logic [31:0] MASK_A = {8'hFF, 8'hFF, 8'b0001_1000, 8'hFF};
  localparam logic [31:0] MASK_B = {4{8'hFF}};

  logic         sysclk = 1'b0;
  logic         poc_pad, clk2_pad, sync_pad, err_clear;
  logic [N-1:0] req;
  logic [4*N-1:0] req_data;

  logic [N-1:0] grant_a, grant_b;
  logic [3:0]   data_out_a, data_out_b;
  logic         data_dir_a, data_dir_b, conflict_a, conflict_b;
  logic [2:0]   phase_a, phase_b;
  logic         phase_valid_a, phase_valid_b;
`ifdef MCS4_BUS_ERR_EN
  logic         err_sticky_a, err_sticky_b;
  logic [7:0]   err_count_a, err_count_b;
`endif

  always #5 sysclk = ~sysclk;

  mcs4_bus_arbiter #(.N_REQ(N), .PHASE_MASK(MASK_A), .RESYNC(RS)) dut_a (
    .sysclk(sysclk), .poc_pad(poc_pad), .clk2_pad(clk2_pad), .sync_pad(sync_pad),
    .req(req), .req_data(req_data),
`ifdef MCS4_BUS_ERR_EN
    .err_clear(err_clear), .err_sticky(err_sticky_a), .err_count(err_count_a),
`endif
    .grant(grant_a), .data_out(data_out_a), .data_dir(data_dir_a),
    .phase(phase_a), .phase_valid(phase_valid_a), .conflict(conflict_a)
  );

  mcs4_bus_arbiter #(.N_REQ(N), .PHASE_MASK(MASK_B), .RESYNC(RS)) dut_b (
    .sysclk(sysclk), .poc_pad(poc_pad), .clk2_pad(clk2_pad), .sync_pad(sync_pad),
    .req(req), .req_data(req_data),
`ifdef MCS4_BUS_ERR_EN
    .err_clear(err_clear), .err_sticky(err_sticky_b), .err_count(err_count_b),
`endif
    .grant(grant_b), .data_out(data_out_b), .data_dir(data_dir_b),
    .phase(phase_b), .phase_valid(phase_valid_b), .conflict(conflict_b)
  );

  // Behavioural model state
  logic [31:0]  m_mask [2];
  logic         m_hc [4];
  logic         m_hs [4];
  logic [2:0]   m_phase;
  logic         m_valid;
  logic [N-1:0] m_grant [2];
  logic [3:0]   m_dout [2];
  logic         m_dir [2];
  logic         m_conf [2];
  logic [7:0]   m_errc [2];
  logic         m_errs [2];

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one sysclk edge using the inputs present before it.
  task automatic model_update();
    logic rise, syn;
    rise = m_hc[RS] & ~m_hc[RS+1];
    syn  = m_hs[RS];
    for (int k = 0; k < 2; k++) begin
      int         cnt;
      logic [N-1:0] g;
      logic [3:0] d;
      cnt = 0; g = '0; d = '0;
      for (int i = 0; i < N; i++) begin
        if (req[i] && m_mask[k][8*i + int'(m_phase)] && m_valid) begin
          cnt++;
          if (g == '0) begin
            g[i] = 1'b1;
            d    = req_data[4*i +: 4];
          end
        end
      end
      if (poc_pad) begin
        g = '0; d = '0; cnt = 0;
      end
      m_grant[k] = g;
      m_dout[k]  = d;
      m_dir[k]   = (g != '0);
      m_conf[k]  = (cnt > 1);
      if (poc_pad) begin
        m_errc[k] = 8'd0; m_errs[k] = 1'b0;
      end else if (err_clear) begin
        m_errc[k] = m_conf[k] ? 8'd1 : 8'd0; m_errs[k] = m_conf[k];
      end else if (m_conf[k]) begin
        m_errs[k] = 1'b1;
        if (m_errc[k] < 8'd255) m_errc[k] = m_errc[k] + 8'd1;
      end
    end
    if (poc_pad) begin
      m_phase = 3'd7; m_valid = 1'b0;
    end else if (rise) begin
      if (syn) begin
        m_phase = 3'd0; m_valid = 1'b1;
      end else begin
        m_phase = 3'((int'(m_phase) + 1) % 8);
      end
    end
    for (int j = 3; j > 0; j--) begin
      m_hc[j] = m_hc[j-1];
      m_hs[j] = m_hs[j-1];
    end
    m_hc[0] = clk2_pad;
    m_hs[0] = sync_pad;
  endtask

  task automatic check_all();
    chk("grant_a",    32'(grant_a),       32'(m_grant[0]));
    chk("grant_b",    32'(grant_b),       32'(m_grant[1]));
    chk("dout_a",     32'(data_out_a),    32'(m_dout[0]));
    chk("dout_b",     32'(data_out_b),    32'(m_dout[1]));
    chk("dir_a",      32'(data_dir_a),    32'(m_dir[0]));
    chk("dir_b",      32'(data_dir_b),    32'(m_dir[1]));
    chk("conflict_a", 32'(conflict_a),    32'(m_conf[0]));
    chk("conflict_b", 32'(conflict_b),    32'(m_conf[1]));
    chk("phase_a",    32'(phase_a),       32'(m_phase));
    chk("phase_b",    32'(phase_b),       32'(m_phase));
    chk("valid_a",    32'(phase_valid_a), 32'(m_valid));
    chk("valid_b",    32'(phase_valid_b), 32'(m_valid));
`ifdef MCS4_BUS_ERR_EN
    chk("errc_a",     32'(err_count_a),   32'(m_errc[0]));
    chk("errc_b",     32'(err_count_b),   32'(m_errc[1]));
    chk("errs_a",     32'(err_sticky_a),  32'(m_errs[0]));
    chk("errs_b",     32'(err_sticky_b),  32'(m_errs[1]));
`endif
  endtask

  task automatic step();
    @(posedge sysclk);
    model_update();
    #1;
    check_all();
  endtask

  // One clk2 period; smode 0: sync high only while in X3, 1: sync low, 2: sync high.
  task automatic clk2_period(input int smode, input bit rnd, input bit rpoc);
    int hi, lo;
    hi = $urandom_range(3, 5);
    lo = $urandom_range(3, 5);
    sync_pad = (smode == 2) ? 1'b1 : (smode == 1) ? 1'b0 : (m_phase == 3'd7);
    clk2_pad = 1'b1;
    for (int c = 0; c < hi + lo; c++) begin
      if (c == hi) clk2_pad = 1'b0;
      if (rnd) begin
        req      = 4'($urandom);
        req_data = 16'($urandom);
        poc_pad  = rpoc && ($urandom_range(0, 47) == 0);
      end
      step();
    end
    poc_pad = 1'b0;
  endtask

  initial begin
    m_mask[0] = MASK_A;
    m_mask[1] = MASK_B;
    for (int j = 0; j < 4; j++) begin
      m_hc[j] = 1'b0; m_hs[j] = 1'b0;
    end
    m_phase = 3'd7; m_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_grant[k] = '0; m_dout[k] = '0; m_dir[k] = 1'b0; m_conf[k] = 1'b0;
      m_errc[k] = 8'd0; m_errs[k] = 1'b0;
    end
    poc_pad = 1'b1; clk2_pad = 1'b0; sync_pad = 1'b0; err_clear = 1'b0;
    req = 4'hF; req_data = 16'h1234;

    // Reset held with all requests active
    repeat (3) step();
    chk("rst_grant", 32'(grant_a), 32'd0);
    chk("rst_dir",   32'(data_dir_b), 32'd0);
    chk("rst_phase", 32'(phase_a), 32'd7);
    chk("rst_valid", 32'(phase_valid_b), 32'd0);
    poc_pad = 1'b0; req = '0;

    // Phase tracking: sync only in X3, random requests throughout
    for (int k = 0; k < 9; k++) begin
      clk2_period(0, 1'b1, 1'b0);
      chk("trk_phase", 32'(phase_a), 32'(k % 8));
      chk("trk_valid", 32'(phase_valid_b), 32'd1);
    end

    // Random traffic with occasional resets landing anywhere in the cycle
    repeat (24) clk2_period(0, 1'b1, 1'b1);

    // Mask: requester 1 restricted to M1/M2 on instance A
    req = 4'b0010; req_data = 16'h00A0;
    poc_pad = 1'b1; step(); poc_pad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      clk2_period(0, 1'b0, 1'b0);
      chk("mask_dout", 32'(data_out_a), (k == 3 || k == 4) ? 32'hA : 32'h0);
      chk("mask_dir",  32'(data_dir_a), (k == 3 || k == 4) ? 32'd1 : 32'd0);
    end

    // Priority in X2: requesters 1 and 2 both eligible on instance B
    req = '0;
    for (int k = 0; k < 7; k++) clk2_period(0, 1'b0, 1'b0);
    chk("x2_phase", 32'(phase_b), 32'd6);
    req = 4'b0110; req_data = 16'h0530;
    step();
    chk("prio_grant_b", 32'(grant_b), 32'b0010);
    chk("prio_dout_b",  32'(data_out_b), 32'h3);
    chk("prio_conf_b",  32'(conflict_b), 32'd1);
    chk("prio_grant_a", 32'(grant_a), 32'b0100);
    chk("prio_conf_a",  32'(conflict_a), 32'd0);
    req = '0;
    step();
    chk("prio_conf_once", 32'(conflict_b), 32'd0);

    // Mid-operation reset during a granted M1
    req = 4'b0010; req_data = 16'h00A0;
    for (int k = 0; k < 5; k++) clk2_period(0, 1'b0, 1'b0);
    chk("m1_grant_a", 32'(grant_a), 32'b0010);
    poc_pad = 1'b1; step(); poc_pad = 1'b0;
    chk("poc_grant_a", 32'(grant_a), 32'd0);
    chk("poc_valid",   32'(phase_valid_a), 32'd0);
    chk("poc_phase",   32'(phase_a), 32'd7);
    for (int k = 0; k < 2; k++) begin
      clk2_period(1, 1'b0, 1'b0);
      chk("nosync_grant_b", 32'(grant_b), 32'd0);
      chk("nosync_valid",   32'(phase_valid_b), 32'd0);
    end
    chk("nosync_phase", 32'(phase_b), 32'd1);
    clk2_period(2, 1'b0, 1'b0);
    chk("resync_grant_b", 32'(grant_b), 32'b0010);
    chk("resync_grant_a", 32'(grant_a), 32'd0);
    for (int k = 0; k < 3; k++) clk2_period(0, 1'b0, 1'b0);
    chk("regrant_a", 32'(grant_a), 32'b0010);

`ifdef MCS4_BUS_ERR_EN
    // Saturating error count under continuous conflicts, then clears
    req = 4'b0011;
    repeat (300) step();
    chk("err_sat",    32'(err_count_b), 32'hFF);
    chk("err_sticky", 32'(err_sticky_b), 32'd1);
    err_clear = 1'b1; req = '0;
    step();
    err_clear = 1'b0;
    chk("err_clr_cnt", 32'(err_count_b), 32'd0);
    chk("err_clr_stk", 32'(err_sticky_b), 32'd0);
    err_clear = 1'b1; req = 4'b0011;
    step();
    err_clear = 1'b0; req = '0;
    chk("err_clr_conf", 32'(err_count_b), 32'd1);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
